// File: rtl/i2s_audio_tx.sv
// I2S master transmitter: 16-bit mono sample duplicated on left and right channels, 32 BCLK per channel.
// The block generates BCLK and LRCK itself and can convert offset-binary input, mute, and attenuate by a power of two.
module i2s_audio_tx #(
  parameter int unsigned BCLK_HALF     = 8,
  parameter int unsigned OFFSET_BINARY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        mute,
  input  logic [3:0]  atten,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat,
  output logic        frame_start
);

  localparam int unsigned      CNT_W   = $clog2(BCLK_HALF);
  localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(BCLK_HALF - 1);
  localparam logic [15:0]      SIGN_FX = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;

  logic [15:0]      s1_q, s2_q;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_idx_q, bit_idx_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             fs_q, fs_d;
  logic [15:0]      word_q, word_d;

  logic               tc;
  logic               fall_ev;
  logic [4:0]         slot;
  logic [15:0]        conv;
  logic signed [15:0] shifted;
  logic [15:0]        latch_word;

  // Word prepared for the latch: sign fix, arithmetic shift, then mute override.
  always_comb begin
    conv       = s2_q ^ SIGN_FX;
    shifted    = $signed(conv) >>> atten;
    latch_word = mute ? '0 : shifted;
  end

  always_comb begin
    tc        = (div_cnt_q == DIV_TC);
    fall_ev   = tc & bclk_q;
    div_cnt_d = tc ? '0 : div_cnt_q + CNT_W'(1);
    bclk_d    = tc ? ~bclk_q : bclk_q;

    bit_idx_d = bit_idx_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    word_d    = word_q;
    fs_d      = 1'b0;
    slot      = '0;

    if (fall_ev) begin
      bit_idx_d = bit_idx_q + 6'd1;
      lrck_d    = bit_idx_d[5];
      slot      = bit_idx_d[4:0];
      if (bit_idx_q == 6'd63) begin
        word_d = latch_word;
        fs_d   = 1'b1;
      end
      // Slot 0 is the I2S one-bit delay, so the word latched on this same edge is never needed here.
      if (slot >= 5'd1 && slot <= 5'd16) begin
        dat_d = word_q[4'(5'd16 - slot)];
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_idx_q <= '0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      fs_q      <= 1'b0;
      word_q    <= '0;
    end else begin
      s1_q      <= sample_in;
      s2_q      <= s1_q;
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_idx_q <= bit_idx_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
      fs_q      <= fs_d;
      word_q    <= word_d;
    end
  end

  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign frame_start = fs_q;

endmodule

// File: doc/i2s_audio_tx.md
# i2s_audio_tx

Downstream stage of the Karplus-Strong synthesizer. It takes the 16-bit `syn_guitar` sample stream and serializes it to the board audio codec in standard I2S format. The same mono sample goes on both channels. The block generates BCLK and LRCK itself as master. It also converts offset-binary samples to two's complement and applies mute and power-of-two attenuation.

## Interface
- `BCLK_HALF`, default 8: clk cycles per BCLK half-period; must be ≥2. With a 50 MHz clk this gives BCLK 3.125 MHz and fs ≈ 48.8 kHz.
- `OFFSET_BINARY`, default 1: when 1, invert `sample_in[15]` before use (unsigned to signed).

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high.
- `sample_in`  in  16: audio sample, typically `syn_guitar`. Its update timing is unrelated to the frame, since the synthesizer runs on a derived clock.
- `mute`  in  1: when 1, the latched sample is 0.
- `atten`  in  4: arithmetic right-shift amount, 0–15.
- `aud_bclk`  out  1: I2S bit clock.
- `aud_daclrck`  out  1: word select; 0 = left, 1 = right.
- `aud_dacdat`  out  1: serial data, MSB first.
- `frame_start`  out  1: one-clk pulse when a new sample is latched.

## Operation
- Input capture:
  - `sample_in` passes through two register stages, `s1` then `s2`, every clk.
  - This filters glitches where the source changes mid-update.
- BCLK generator:
  - `div_cnt` counts 0..BCLK_HALF-1.
  - At terminal count, `div_cnt` returns to 0 and `aud_bclk` toggles.
  - A toggle from 1 to 0 is a "fall event"; a toggle from 0 to 1 is a "rise event".
- Bit counter `bit_idx`, 6 bits, range 0..63:
  - Increments on each fall event and wraps from 63 to 0.
  - `aud_daclrck` = `bit_idx[5]`, registered so it changes on the fall event.
- Sample latch, performed on the fall event where `bit_idx` goes 63→0:
  - Take `s2`. If OFFSET_BINARY, invert bit 15.
  - Arithmetic-shift right by `atten`, keeping sign. For example, 0x8000 >>> 15 = 0xFFFF.
  - Force the result to 0 if `mute`.
  - Store it in `word`.
  - Assert `frame_start` for that single clk.
- Data slot, with `slot` = `bit_idx[4:0]` after the fall event:
  - `slot` 0 drives 0. This is the I2S one-bit delay.
  - `slot` 1..16 drives `word[16-slot]`.
  - `slot` 17..31 drives 0 (padding).
  - Left and right channels carry the same `word`.
  - `aud_dacdat` changes only on fall events, so the codec samples it on the rise event.
- `mute` and `atten` are sampled only at the latch. Changes between latches take effect at the next frame.
- Sizing: about 150–250 lines of RTL, with no FSM beyond these counters.

## Timing
- Reset values:
  - `aud_bclk`, `aud_daclrck`, `aud_dacdat`, `frame_start` = 0.
  - `div_cnt`, `bit_idx`, `word`, `s1`, `s2` = 0.
- After reset deassertion:
  - First rise event at clk BCLK_HALF.
  - First fall event at clk 2·BCLK_HALF; this sets `bit_idx` to 1.
  - The first real latch happens at the wrap from 63 to 0, at clk 128·BCLK_HALF.
- BCLK period is 2·BCLK_HALF clk cycles. A frame is 64 BCLK periods, i.e. 128·BCLK_HALF clk cycles. This is exact and has no drift.
- Latency:
  - A `sample_in` change is in `s2` after 2 clk.
  - It is used at the next latch.
  - Its MSB appears on `aud_dacdat` one BCLK period after `frame_start`, on the fall event that moves `bit_idx` from 0 to 1.
- Between a change and its `s2` update, the latch may use the old or the new value. It never uses a mix of bits from the two.
- Reset asserted mid-frame: all state returns to reset values on the next clk, and outputs go to 0 immediately with no partial word. The restart sequence is identical to power-up.
- `frame_start` is high for exactly 1 clk per frame, coincident with the `aud_daclrck` 1→0 transition.

## Test plan
- Reset with BCLK_HALF=8:
  - `aud_bclk` rises at clk 8 and falls at clk 16.
  - `aud_bclk` period is 16 clk.
  - `frame_start` pulses every 1024 clk.
  - `aud_daclrck` has a 50% duty cycle and changes only on `aud_bclk` falling edges.
- `sample_in`=0xC000, OFFSET_BINARY=1, `atten`=0, `mute`=0:
  - Both channels serialize 0x4000.
  - Slot 0 is 0, slot 1 is 0, slot 2 is 1, and the remaining slots are 0.
  - A checker decoding on BCLK rises reads L=R=0x4000.
- `sample_in`=0x0000 with OFFSET_BINARY=1, which maps to 0x8000:
  - `atten`=15 gives decoded 0xFFFF; `atten`=1 gives 0xC000.
  - Set `mute`=1 mid-frame: the current frame is still 0xC000 and the next frame is 0x0000.
- Change `sample_in` every 37 clk through values 0x1234, 0xABCD, 0x5555:
  - Every decoded word equals one of the input values XOR 0x8000.
  - No word is a mixed value.
  - L equals R in every frame.
- Assert `reset` for 1 clk at `bit_idx`=20 of a frame:
  - All outputs read 0 on the following clk.
  - The next `aud_bclk` rise is BCLK_HALF clk later.
- BCLK_HALF=2 (minimum):
  - `aud_bclk` period is 4 clk.
  - The frame is 256 clk long.
  - Decoded data matches 0x7FFF input with OFFSET_BINARY=0.
